// File: rtl/led_share_arbiter.sv
// led_share_arbiter
//   Round-robin arbiter that shares the board's user LEDs between NUM_REQ
//   requesters. Request 0 is the HPS LED PIO export; the others are fabric
//   status sources. Only one owner drives the LEDs at a time. A blanking gap
//   separates consecutive owners. A hold-time limit forces a handover when an
//   owner has held the LEDs too long while others are waiting.
//
// Ports
//   clk_clk      in   1                single clock for all logic
//   reset_reset  in   1                synchronous, active-high reset
//   req          in   NUM_REQ          level request per requester
//   value        in   NUM_REQ*LED_W    flat LED patterns, requester i at [i*LED_W +: LED_W]
//   grant        out  NUM_REQ          one-hot current owner, zero when none
//   owner_id     out  clog2(NUM_REQ)   index of the current or last owner
//   leds         out  LED_W            registered LED drive
//   timeout      out  1                one-cycle pulse on a forced handover

module led_share_arbiter #(
    parameter int              NUM_REQ    = 4,
    parameter int              LED_W      = 10,
    parameter int              MAX_HOLD   = 1000,
    parameter int              GAP_CYCLES = 2,
    parameter logic [LED_W-1:0] IDLE_VALUE = '0
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*LED_W-1:0]     value,
    output logic [NUM_REQ-1:0]           grant,
    output logic [$clog2(NUM_REQ)-1:0]   owner_id,
    output logic [LED_W-1:0]             leds,
    output logic                         timeout
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int HOLD_W = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int GAP_W  = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    // hold_cnt reads k-1 during the k-th owned cycle, so triggering at
    // MAX_HOLD-1 gives each owner exactly MAX_HOLD cycles before handover.
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_TRIG = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } state_t;

    state_t              state, state_next;
    logic [NUM_REQ-1:0]  grant_next;
    logic [ID_W-1:0]     owner_next;
    logic [LED_W-1:0]    leds_next;
    logic                timeout_next;
    logic [HOLD_W-1:0]   hold_cnt, hold_next;
    logic [GAP_W-1:0]    gap_cnt, gap_next;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic [ID_W-1:0]     cand;
    int                  idx;
    logic [NUM_REQ-1:0]  owner_mask;
    logic                others_waiting;
    logic                limit_hit;

    // Round-robin search starting just after the last owner. Because the
    // previous owner is examined last, a forced-out owner that keeps its
    // request high naturally queues behind everyone else.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(owner_id) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Helper terms for the ownership state: who else is asking, and whether
    // the current owner has used up its allowance.
    always_comb begin
        owner_mask     = NUM_REQ'(1) << owner_id;
        others_waiting = |(req & ~owner_mask);
        limit_hit      = (MAX_HOLD != 0) && (hold_cnt >= HOLD_TRIG);
    end

    // Next-state and next-output logic. Every output is computed here and
    // registered below, so the pins never see combinational glitches.
    always_comb begin
        state_next   = state;
        grant_next   = grant;
        owner_next   = owner_id;
        leds_next    = leds;
        timeout_next = 1'b0;
        hold_next    = hold_cnt;
        gap_next     = gap_cnt;

        case (state)
            IDLE: begin
                grant_next = '0;
                leds_next  = IDLE_VALUE;
                if (win_found) begin
                    state_next = OWN;
                    grant_next = NUM_REQ'(1) << win_idx;
                    owner_next = win_idx;
                    leds_next  = value[win_idx*LED_W +: LED_W];
                    hold_next  = '0;
                end
            end

            OWN: begin
                leds_next = value[owner_id*LED_W +: LED_W];
                if (hold_cnt != HOLD_SAT) begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
                // A voluntary release wins over a coincident limit hit, so
                // timeout only fires while the owner is still requesting.
                if (!req[owner_id] || (limit_hit && others_waiting)) begin
                    timeout_next = req[owner_id];
                    grant_next   = '0;
                    leds_next    = IDLE_VALUE;
                    hold_next    = '0;
                    gap_next     = GAP_LOAD;
                    state_next   = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end

            GAP: begin
                grant_next = '0;
                leds_next  = IDLE_VALUE;
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt - GAP_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                grant_next = '0;
                leds_next  = IDLE_VALUE;
            end
        endcase
    end

    // State and output registers. Reset parks the arbiter idle with the last
    // owner set to NUM_REQ-1 so requester 0 has top priority afterwards.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state    <= IDLE;
            grant    <= '0;
            owner_id <= ID_W'(NUM_REQ - 1);
            leds     <= IDLE_VALUE;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            owner_id <= owner_next;
            leds     <= leds_next;
            timeout  <= timeout_next;
            hold_cnt <= hold_next;
            gap_cnt  <= gap_next;
        end
    end

endmodule
